biquad_coef_loader: RTL and testbench

Coefficient front-end for the IIR biquad stage. It collects five new filter coefficients (b0, b1, b2, a1, a2) in a shadow bank through a valid/ready write port, and checks a1/a2 against the biquad stability triangle. It then swaps the whole set into the active bank atomically on a sample boundary. This guarantees the downstream filter never runs one sample with a mixed old/new coefficient set.

---
 rtl/biquad_pkg.sv | 21 ++
 rtl/biquad_coef_loader_if.sv | 12 +
 rtl/biquad_stab_check.sv | 26 ++
 rtl/biquad_coef_loader.sv | 109 ++++++++++
 tb/tb_biquad_coef_loader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/biquad_pkg.sv
// Shared constants and types for the biquad coefficient front-end.
// Coefficients are signed Q2.8, so COEF_ONE is the encoding of 1.0.
package biquad_pkg;

  localparam int COEF_W    = 10;
  localparam int COEF_FRAC = 8;
  localparam int COEF_ONE  = 256;

  localparam logic [2:0] ADDR_B0 = 3'd0;
  localparam logic [2:0] ADDR_B1 = 3'd1;
  localparam logic [2:0] ADDR_B2 = 3'd2;
  localparam logic [2:0] ADDR_A1 = 3'd3;
  localparam logic [2:0] ADDR_A2 = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PENDING = 2'd2
  } coef_state_t;

endpackage

// File: rtl/biquad_coef_loader_if.sv
// Valid/ready write port into the shadow coefficient bank.
interface biquad_coef_loader_if #(
  parameter int CW = 10
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [2:0]           wr_addr;
  logic signed [CW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/biquad_stab_check.sv
// Combinational biquad stability-triangle test on a1/a2.
// Stable iff -1 < a2 < 1 and |a1| < 1 + a2, evaluated losslessly in CW+2 bits.
module biquad_stab_check
  import biquad_pkg::*;
#(
  parameter int CW = COEF_W
) (
  input  logic signed [CW-1:0] a1,
  input  logic signed [CW-1:0] a2,
  output logic                 stable
);

  logic signed [CW+1:0] a1_x;
  logic signed [CW+1:0] a2_x;
  logic signed [CW+1:0] a1_abs;
  logic signed [CW+1:0] one_x;

  // Two extra bits keep |-512| and 256+a2 exact without wrapping.
  assign a1_x   = $signed({{2{a1[CW-1]}}, a1});
  assign a2_x   = $signed({{2{a2[CW-1]}}, a2});
  assign one_x  = $signed((CW+2)'(COEF_ONE));
  assign a1_abs = a1_x[CW+1] ? -a1_x : a1_x;

  assign stable = (a2_x > -one_x) && (a2_x < one_x) && (a1_abs < (one_x + a2_x));

endmodule

// File: rtl/biquad_coef_loader.sv
// Shadow/active coefficient banks with a stability-checked, sample-aligned
// atomic swap so the filter never sees a mixed coefficient set.
module biquad_coef_loader
  import biquad_pkg::*;
#(
  parameter int                   CW     = COEF_W,
  parameter logic signed [CW-1:0] RST_B0 = 10'sd256,
  parameter logic signed [CW-1:0] RST_B1 = '0,
  parameter logic signed [CW-1:0] RST_B2 = '0,
  parameter logic signed [CW-1:0] RST_A1 = '0,
  parameter logic signed [CW-1:0] RST_A2 = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  biquad_coef_loader_if.slave  bus,
  input  logic                 commit_req,
  input  logic                 sample_tick,
  input  logic                 err_clr,
  output logic signed [CW-1:0] b0,
  output logic signed [CW-1:0] b1,
  output logic signed [CW-1:0] b2,
  output logic signed [CW-1:0] a1,
  output logic signed [CW-1:0] a2,
  output logic                 coef_updated,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam logic signed [CW-1:0] RST_VAL [5] = '{RST_B0, RST_B1, RST_B2, RST_A1, RST_A2};

  coef_state_t          state, state_next;
  logic signed [CW-1:0] shadow [5];
  logic signed [CW-1:0] active [5];
  logic                 stable;
  logic                 wr_fire;
  logic                 addr_ok;
  logic                 apply;
  logic [1:0]           err_set;

  biquad_stab_check #(.CW(CW)) u_stab (
    .a1     (shadow[ADDR_A1]),
    .a2     (shadow[ADDR_A2]),
    .stable (stable)
  );

  assign wr_fire = bus.wr_valid && bus.wr_ready;
  assign addr_ok = (bus.wr_addr <= ADDR_A2);
  assign apply   = (state == PENDING) && sample_tick;
  assign err_set = {wr_fire && !addr_ok, (state == CHECK) && !stable};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The shadow bank only accepts writes in IDLE, so it is frozen while checked or pending.
  always_comb begin
    state_next   = state;
    bus.wr_ready = (state == IDLE);
    busy         = (state != IDLE);
    unique case (state)
      IDLE:    if (commit_req)  state_next = CHECK;
      CHECK:   state_next = stable ? PENDING : IDLE;
      PENDING: if (sample_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RST_VAL;
    end else if (wr_fire && addr_ok) begin
      shadow[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= RST_VAL;
      coef_updated <= 1'b0;
    end else begin
      coef_updated <= apply;
      if (apply) begin
        active <= shadow;
      end
    end
  end

  // A same-cycle clear wins over any new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 2'b00;
    end else if (err_clr) begin
      err <= 2'b00;
    end else begin
      err <= err | err_set;
    end
  end

  assign b0 = active[ADDR_B0];
  assign b1 = active[ADDR_B1];
  assign b2 = active[ADDR_B2];
  assign a1 = active[ADDR_A1];
  assign a2 = active[ADDR_A2];

endmodule

// File: tb/tb_biquad_coef_loader.sv
// Directed self-checking bench for biquad_coef_loader.
module tb_biquad_coef_loader;
  import biquad_pkg::*;

  localparam int CW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 commit_req = 1'b0;
  logic                 sample_tick = 1'b0;
  logic                 err_clr = 1'b0;
  logic signed [CW-1:0] b0, b1, b2, a1, a2;
  logic                 coef_updated;
  logic                 busy;
  logic [1:0]           err;
  int                   passed = 0;
  int                   total = 0;

  biquad_coef_loader_if #(.CW(CW)) bus ();

  biquad_coef_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .commit_req   (commit_req),
    .sample_tick  (sample_tick),
    .err_clr      (err_clr),
    .b0           (b0),
    .b1           (b1),
    .b2           (b2),
    .a1           (a1),
    .a2           (a2),
    .coef_updated (coef_updated),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_coefs(input string tag, input logic [9:0] e0, input logic [9:0] e1,
                             input logic [9:0] e2, input logic [9:0] e3, input logic [9:0] e4);
    check_output({tag, ".b0"}, 16'($unsigned(b0)), 16'(e0));
    check_output({tag, ".b1"}, 16'($unsigned(b1)), 16'(e1));
    check_output({tag, ".b2"}, 16'($unsigned(b2)), 16'(e2));
    check_output({tag, ".a1"}, 16'($unsigned(a1)), 16'(e3));
    check_output({tag, ".a2"}, 16'($unsigned(a2)), 16'(e4));
  endtask

  task automatic write_coef(input logic [2:0] addr, input logic [9:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = $signed(data);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = '0;

    // Reset state
    #12;
    check_coefs("rst", 10'h100, 10'h000, 10'h000, 10'h000, 10'h000);
    check_output("rst.wr_ready", 16'(bus.wr_ready), 16'd1);
    check_output("rst.err", 16'(err), 16'd0);
    check_output("rst.busy", 16'(busy), 16'd0);
    check_output("rst.coef_updated", 16'(coef_updated), 16'd0);
    rst_n = 1'b1;
    step();

    // Full load and commit, tick five cycles after the commit
    write_coef(ADDR_B0, 10'h100);
    write_coef(ADDR_B1, 10'h1DF);
    write_coef(ADDR_B2, 10'h100);
    write_coef(ADDR_A1, 10'h2CD);
    write_coef(ADDR_A2, 10'h06E);
    check_coefs("load.pre", 10'h100, 10'h000, 10'h000, 10'h000, 10'h000);
    pulse_commit();
    check_output("load.check_busy", 16'(busy), 16'd1);
    check_output("load.check_ready", 16'(bus.wr_ready), 16'd0);
    step();
    check_output("load.pend_busy", 16'(busy), 16'd1);
    check_output("load.pend_err", 16'(err), 16'd0);
    step();
    step();
    step();
    check_coefs("load.hold", 10'h100, 10'h000, 10'h000, 10'h000, 10'h000);
    check_output("load.no_upd", 16'(coef_updated), 16'd0);
    pulse_tick();
    check_coefs("load.apply", 10'h100, 10'h1DF, 10'h100, 10'h2CD, 10'h06E);
    check_output("load.upd", 16'(coef_updated), 16'd1);
    check_output("load.busy_fall", 16'(busy), 16'd0);
    step();
    check_output("load.upd_once", 16'(coef_updated), 16'd0);

    // Unstable a2 = 1.0 is rejected
    write_coef(ADDR_A2, 10'h100);
    pulse_commit();
    step();
    check_output("unstab.err", 16'(err), 16'd1);
    check_output("unstab.busy", 16'(busy), 16'd0);
    check_output("unstab.no_upd", 16'(coef_updated), 16'd0);
    check_coefs("unstab.keep", 10'h100, 10'h1DF, 10'h100, 10'h2CD, 10'h06E);
    pulse_clr();
    check_output("unstab.clr", 16'(err), 16'd0);

    // Boundary a2 = -255, a1 = 0 is accepted
    write_coef(ADDR_A1, 10'h000);
    write_coef(ADDR_A2, 10'h301);
    pulse_commit();
    step();
    check_output("bound.pend", 16'(busy), 16'd1);
    check_output("bound.err", 16'(err), 16'd0);
    pulse_tick();
    check_coefs("bound.apply", 10'h100, 10'h1DF, 10'h100, 10'h000, 10'h301);
    check_output("bound.upd", 16'(coef_updated), 16'd1);

    // Invalid address flags err[1] and leaves the shadow alone
    write_coef(3'd6, 10'h3FF);
    check_output("badaddr.err", 16'(err), 16'd2);
    // Clear beats a simultaneous new error
    err_clr = 1'b1;
    write_coef(3'd7, 10'h155);
    err_clr = 1'b0;
    check_output("clr_prio.err", 16'(err), 16'd0);

    // Held write during PENDING waits for the apply
    pulse_commit();
    step();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_B0;
    bus.wr_data  = 10'sh080;
    step();
    check_output("hold.ready_lo", 16'(bus.wr_ready), 16'd0);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_coefs("hold.apply", 10'h100, 10'h1DF, 10'h100, 10'h000, 10'h301);
    check_output("hold.ready_hi", 16'(bus.wr_ready), 16'd1);
    step();
    bus.wr_valid = 1'b0;
    pulse_commit();
    step();
    pulse_tick();
    check_coefs("hold.write", 10'h080, 10'h1DF, 10'h100, 10'h000, 10'h301);

    // Asynchronous reset while PENDING discards the commit
    write_coef(ADDR_B1, 10'h011);
    pulse_commit();
    step();
    check_output("arst.pend", 16'(busy), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_coefs("arst.async", 10'h100, 10'h000, 10'h000, 10'h000, 10'h000);
    check_output("arst.busy", 16'(busy), 16'd0);
    step();
    rst_n = 1'b1;
    pulse_tick();
    check_output("arst.no_upd", 16'(coef_updated), 16'd0);
    check_coefs("arst.after", 10'h100, 10'h000, 10'h000, 10'h000, 10'h000);

    // Tick during CHECK is ignored; the next tick in PENDING applies
    write_coef(ADDR_A1, 10'h010);
    pulse_commit();
    pulse_tick();
    check_output("ckt.busy", 16'(busy), 16'd1);
    check_output("ckt.no_upd", 16'(coef_updated), 16'd0);
    check_output("ckt.a1_old", 16'($unsigned(a1)), 16'h000);
    step();
    pulse_tick();
    check_coefs("ckt.apply", 10'h100, 10'h000, 10'h000, 10'h010, 10'h000);
    check_output("ckt.upd", 16'(coef_updated), 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
